ysyx_25030093_idu_inbuf: RTL

Receiving end of the IFU fetch handshake: accepts instruction/PC pairs from the IFU over valid/ready and buffers them in a 2-entry skid buffer. It pre-classifies each opcode at capture and presents the entries in order to the IDU decode logic over a second valid/ready pair. It sits between the IFU output and the IDU. It also provides a flush path for redirects and a count of delivered instructions.

---
 rtl/ysyx_25030093_idu_inbuf_if.sv | 29 ++
 rtl/ysyx_25030093_idu_inbuf.sv | 89 ++++++++
 2 files changed

// File: rtl/ysyx_25030093_idu_inbuf_if.sv
// IFU-to-IDU input buffer bus: fetch handshake in, decode handshake out.
// Also carries the redirect flush and the delivered-instruction count.
interface ysyx_25030093_idu_inbuf_if #(
    parameter int CNT_W = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_inst;
    logic [31:0]      in_pc;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_inst;
    logic [31:0]      out_pc;
    logic [3:0]       out_class;
    logic [CNT_W-1:0] out_cnt;

    modport master (
        output in_valid, in_inst, in_pc, flush, out_ready,
        input  in_ready, out_valid, out_inst, out_pc,
        input  out_class, out_cnt
    );

    modport slave (
        input  in_valid, in_inst, in_pc, flush, out_ready,
        output in_ready, out_valid, out_inst, out_pc,
        output out_class, out_cnt
    );
endinterface

// File: rtl/ysyx_25030093_idu_inbuf.sv
// Two-entry skid buffer between IFU and IDU.
// Opcodes are pre-classified at capture and stored with each entry.
module ysyx_25030093_idu_inbuf #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 32
) (
    input  logic clk,
    input  logic rst,
    ysyx_25030093_idu_inbuf_if.slave bus
);
    localparam logic [1:0] FULL = DEPTH[1:0];

    logic [31:0]      r_inst [DEPTH];
    logic [31:0]      r_pc   [DEPTH];
    logic [3:0]       r_cls  [DEPTH];
    logic             r_wr;
    logic             r_rd;
    logic [1:0]       r_count;
    logic [CNT_W-1:0] r_ocnt;

    logic       w_in_ready;
    logic       w_out_valid;
    logic       w_push;
    logic       w_pop;
    logic [3:0] w_cls;
    logic [6:0] w_op;

    assign w_in_ready  = (r_count != FULL);
    assign w_out_valid = (r_count != 2'd0);
    assign w_push      = bus.in_valid && w_in_ready;
    assign w_pop       = w_out_valid && bus.out_ready;
    assign w_op        = bus.in_inst[6:0];

    always_comb begin
        w_cls = 4'd0;
        unique case (1'b1)
            (w_op == 7'b0110111): w_cls = 4'd1;
            (w_op == 7'b0010111): w_cls = 4'd2;
            (w_op == 7'b1101111): w_cls = 4'd3;
            (w_op == 7'b1100111): w_cls = 4'd4;
            (w_op == 7'b1100011): w_cls = 4'd5;
            (w_op == 7'b0000011): w_cls = 4'd6;
            (w_op == 7'b0100011): w_cls = 4'd7;
            (w_op == 7'b0010011): w_cls = 4'd8;
            (w_op == 7'b0110011): w_cls = 4'd9;
            (w_op == 7'b1110011): w_cls = 4'd10;
            default:              w_cls = 4'd0;
        endcase
    end

    // Storage needs no reset: count gates visibility.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_inst[r_wr] <= bus.in_inst;
            r_pc[r_wr]   <= bus.in_pc;
            r_cls[r_wr]  <= w_cls;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr    <= 1'b0;
            r_rd    <= 1'b0;
            r_count <= 2'd0;
            r_ocnt  <= '0;
        end else begin
            if (w_pop) r_ocnt <= r_ocnt + 1'b1;
            if (bus.flush) begin
                r_wr    <= 1'b0;
                r_rd    <= 1'b0;
                r_count <= 2'd0;
            end else begin
                if (w_push) r_wr <= ~r_wr;
                if (w_pop)  r_rd <= ~r_rd;
                if (w_push && !w_pop)
                    r_count <= r_count + 2'd1;
                else if (w_pop && !w_push)
                    r_count <= r_count - 2'd1;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_inst  = r_inst[r_rd];
    assign bus.out_pc    = r_pc[r_rd];
    assign bus.out_class = r_cls[r_rd];
    assign bus.out_cnt   = r_ocnt;
endmodule
